// File: rtl/mem_pkg.sv
// Shared load/store op encodings, FSM states and lane helpers for the data-memory access unit.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ACK_TIMEOUT_DEF = 255;

  function automatic logic is_misaligned(input op_t op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return a != 2'b00;
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input op_t op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic [3:0] byte_en(input op_t op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return 4'b1111;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b1100 : 4'b0011;
      default:              return 4'b0001 << a;
    endcase
  endfunction

  // Store data is replicated across every lane so memory only needs dm_be.
  function automatic logic [31:0] store_data(input op_t op, input logic [31:0] d);
    case (op)
      OP_SH:   return {2{d[15:0]}};
      OP_SB:   return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension of a memory read word.
// Latency: combinational.
// Backpressure: none; purely a function of its inputs.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  op_type,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op_t'(op_type))
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'b0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns, issues one data-memory request, extends load data.
// Latency: 1 issue + N request (until dm_ack or ACK_TIMEOUT) + 1 done cycle.
// Backpressure: mem_stall holds the pipeline while issuing and waiting for dm_ack.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_op_valid,
  input  logic [2:0]  mem_op_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dmem_out,
  output logic        mem_stall,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  op_t           op;
  op_t           op_q;
  logic [1:0]    lane_q;
  logic          misaligned;
  logic          issue;
  logic [31:0]   ld_data;

  assign op         = op_t'(mem_op_type);
  assign misaligned = is_misaligned(op, mem_addr[1:0]);
  assign issue      = mem_op_valid && !misaligned;

  // Gated by rst so a held instruction cannot stall the pipe during reset.
  assign mem_stall = rst && (((state == ST_IDLE) && issue) || (state == ST_REQ));

  load_extend u_load_extend (
    .op_type (op_q),
    .lane    (lane_q),
    .rdata   (dm_rdata),
    .data    (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= OP_LW;
      lane_q   <= 2'b00;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'h0;
      dm_be    <= 4'h0;
      dm_wdata <= 32'h0;
      dmem_out <= 32'h0;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_op_valid && misaligned) begin
            addr_err <= 1'b1;
          end else if (issue) begin
            dm_req   <= 1'b1;
            dm_we    <= is_store(op);
            dm_addr  <= {mem_addr[31:2], 2'b00};
            dm_be    <= byte_en(op, mem_addr[1:0]);
            dm_wdata <= store_data(op, mem_wdata);
            op_q     <= op;
            lane_q   <= mem_addr[1:0];
            cnt      <= '0;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack is checked first so an ack on the final allowed cycle wins over the timeout.
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (!dm_we) dmem_out <= ld_data;
            state  <= ST_DONE;
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            dm_req   <= 1'b0;
            bus_err  <= 1'b1;
            dmem_out <= 32'h0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with ACK_TIMEOUT=4.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_op_valid = 1'b0;
  logic [2:0]  mem_op_type = 3'd0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'h0;
  logic [31:0] dmem_out;
  logic        mem_stall, addr_err, bus_err;

  always #5 clk = ~clk;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_op_valid(mem_op_valid), .mem_op_type(mem_op_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dmem_out(dmem_out), .mem_stall(mem_stall),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_after;   // REQ cycle index carrying dm_ack, -1 = never
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[10];
  vec_t post_rst;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int   stalls = 0;
    int   k = 0;
    int   n = 0;
    int   nreq;
    bit   done = 1'b0;
    bit   prev_req = 1'b0;
    exp_t e;
    nreq = (v.ack_after < 0) ? 4 : v.ack_after + 1;
    @(posedge clk); #1;
    mem_op_valid = 1'b1;
    mem_op_type  = v.op;
    mem_addr     = v.addr;
    mem_wdata    = v.wdata;
    dm_rdata     = v.rdata;
    sb_q.push_back('{dout: v.dout, berr: (v.ack_after < 0)});
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      dm_ack = 1'b0;
      if (mem_stall) stalls++;
      if (prev_req && !dm_req) begin
        done = 1'b1;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("dmem_out", dmem_out, e.dout);
          chk("bus_err_done", 32'(bus_err), 32'(e.berr));
        end
      end else if (dm_req) begin
        chk("dm_addr", dm_addr, {v.addr[31:2], 2'b00});
        chk("dm_be", 32'(dm_be), 32'(v.be));
        chk("dm_we", 32'(dm_we), 32'(v.we));
        if (v.we) chk("dm_wdata", dm_wdata, v.wd);
        if (k == v.ack_after) dm_ack = 1'b1;
        k++;
      end
      prev_req = dm_req;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(nreq + 1));
    chk("req_cycles", 32'(k), 32'(nreq));
    // Instruction stays valid through DONE; the unit must not re-issue it.
    @(posedge clk); #1;
    mem_op_valid = 1'b0;
    @(negedge clk);
    chk("no_reissue", 32'(dm_req), 32'd0);
    chk("bus_err_pulse", 32'(bus_err), 32'd0);
  endtask

  task automatic misal(input logic [2:0] op, input logic [31:0] addr);
    @(posedge clk); #1;
    mem_op_valid = 1'b1;
    mem_op_type  = op;
    mem_addr     = addr;
    @(negedge clk);
    chk("misal_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    mem_op_valid = 1'b0;
    @(negedge clk);
    chk("addr_err_hi", 32'(addr_err), 32'd1);
    chk("misal_no_req", 32'(dm_req), 32'd0);
    @(negedge clk);
    chk("addr_err_lo", 32'(addr_err), 32'd0);
    chk("misal_no_req2", 32'(dm_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           op      addr          wdata         rdata        ack  be       we    wd            dout
    tbl[0] = '{OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0,  4'b1111, 1'b0, 32'h0,        32'hDEADBEEF};
    tbl[1] = '{OP_LB,  32'h103, 32'h0,        32'h80FF0000, 0,  4'b1000, 1'b0, 32'h0,        32'hFFFFFF80};
    tbl[2] = '{OP_LBU, 32'h103, 32'h0,        32'h80FF0000, 0,  4'b1000, 1'b0, 32'h0,        32'h00000080};
    tbl[3] = '{OP_SH,  32'h102, 32'h1234ABCD, 32'h0,        0,  4'b1100, 1'b1, 32'hABCDABCD, 32'h00000080};
    tbl[4] = '{OP_LH,  32'h102, 32'h0,        32'h80017FFF, 2,  4'b1100, 1'b0, 32'h0,        32'hFFFF8001};
    tbl[5] = '{OP_LHU, 32'h100, 32'h0,        32'h8001F234, 1,  4'b0011, 1'b0, 32'h0,        32'h0000F234};
    tbl[6] = '{OP_SB,  32'h201, 32'h000000A5, 32'h0,        3,  4'b0010, 1'b1, 32'hA5A5A5A5, 32'h0000F234};
    tbl[7] = '{OP_SW,  32'h300, 32'h11223344, 32'h0,        1,  4'b1111, 1'b1, 32'h11223344, 32'h0000F234};
    tbl[8] = '{OP_LB,  32'h101, 32'h0,        32'h00007F00, 0,  4'b0010, 1'b0, 32'h0,        32'h0000007F};
    tbl[9] = '{OP_LW,  32'h104, 32'h0,        32'h12345678, -1, 4'b1111, 1'b0, 32'h0,        32'h00000000};
    post_rst = '{OP_LW, 32'h500, 32'h0,       32'hCAFEF00D, 1,  4'b1111, 1'b0, 32'h0,        32'hCAFEF00D};

    // Reset with an aligned op already presented: nothing may stall or request.
    mem_op_valid = 1'b1;
    mem_op_type  = OP_LW;
    mem_addr     = 32'h100;
    #12;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_dmem_out", dmem_out, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_be", 32'(dm_be), 32'd0);
    chk("rst_errs", {30'b0, addr_err, bus_err}, 32'd0);
    mem_op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_op(tbl[i]);

    // A stray ack while idle must not touch dmem_out or start a request.
    @(negedge clk);
    dm_rdata = 32'h55AA55AA;
    dm_ack   = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("stray_ack_dout", dmem_out, tbl[8].dout);
    chk("stray_ack_req", 32'(dm_req), 32'd0);

    run_op(tbl[9]);

    misal(OP_LW, 32'h101);
    misal(OP_SH, 32'h103);

    // Reset in the second REQ cycle abandons the access immediately.
    @(posedge clk); #1;
    mem_op_valid = 1'b1;
    mem_op_type  = OP_LW;
    mem_addr     = 32'h400;
    dm_rdata     = 32'h00000055;
    @(negedge clk);
    @(negedge clk);
    chk("rq_req1", 32'(dm_req), 32'd1);
    @(negedge clk);
    chk("rq_req2", 32'(dm_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_dm_req", 32'(dm_req), 32'd0);
    chk("arst_stall", 32'(mem_stall), 32'd0);
    chk("arst_dm_addr", dm_addr, 32'h0);
    chk("arst_dm_be", 32'(dm_be), 32'd0);
    chk("arst_dmem_out", dmem_out, 32'h0);
    mem_op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_op(post_rst);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
